mem_arbiter: RTL

Two-master round-robin arbiter that shares the single data-memory port between the IFU (instruction fetch, read-only) and the LSU (loads/stores). It sits between the core front/back ends and the memory access unit. It accepts one request at a time, forwards it over a valid/ready request channel, waits for the memory response and returns it to the owning master. At most one transaction is outstanding.

---
 rtl/mem_arb_pkg.sv | 34 +++
 rtl/rr_arb2.sv | 33 +++
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and defaults for the IFU/LSU data-memory arbiter.
//   arb_state_e : arbiter FSM states
//   master_e    : master identity, used for ownership and last-grant tracking
//   *_IDX       : bit positions of each master in request/grant vectors
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned WMASK_W        = 8;

    localparam int unsigned IFU_IDX = 0;
    localparam int unsigned LSU_IDX = 1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        MST_IFU = 1'b0,
        MST_LSU = 1'b1
    } master_e;

    // Maps a one-hot grant vector to the winning master.
    function automatic master_e grant_owner(input logic [1:0] gnt);
        return gnt[LSU_IDX] ? MST_LSU : MST_IFU;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin picker. A lone requester always wins; on a tie the
//   master that was not granted last time wins.
//   req        in  [1:0]  request vector (bit IFU_IDX = IFU, LSU_IDX = LSU)
//   last_grant in         master granted by the previous arbitration
//   grant      out [1:0]  one-hot grant, all zero when nothing requests
// ----------------------------------------------------------------------------
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  master_e    last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (last_grant == MST_LSU) begin
                    grant[IFU_IDX] = 1'b1;
                end else begin
                    grant[LSU_IDX] = 1'b1;
                end
            end
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single data-memory port between the IFU (read-only) and the
//   LSU. One transaction is outstanding at a time:
//     IDLE -> (master handshake) -> REQ -> (mem handshake) -> WAIT
//          -> (mem response) -> RESP -> IDLE
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     ifu_req_valid/ready, ifu_addr   IFU read request channel
//     ifu_resp_valid                  one-cycle IFU response pulse
//     lsu_req_valid/ready, lsu_addr,
//     lsu_wen, lsu_wdata, lsu_wmask   LSU load/store request channel
//     lsu_resp_valid                  one-cycle LSU response pulse
//     rdata                           response data for the owning master
//     mem_req_valid/ready, mem_addr,
//     mem_wen, mem_wdata, mem_wmask   registered request to memory
//     mem_resp_valid, mem_rdata       memory response (no backpressure)
// ----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
)
(
    input  logic               clk,
    input  logic               rst_n,

    input  logic               ifu_req_valid,
    output logic               ifu_req_ready,
    input  logic [ADDR_W-1:0]  ifu_addr,
    output logic               ifu_resp_valid,

    input  logic               lsu_req_valid,
    output logic               lsu_req_ready,
    input  logic [ADDR_W-1:0]  lsu_addr,
    input  logic               lsu_wen,
    input  logic [DATA_W-1:0]  lsu_wdata,
    input  logic [WMASK_W-1:0] lsu_wmask,
    output logic               lsu_resp_valid,

    output logic [DATA_W-1:0]  rdata,

    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_wen,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [WMASK_W-1:0] mem_wmask,
    input  logic               mem_resp_valid,
    input  logic [DATA_W-1:0]  mem_rdata
);

    arb_state_e state_q;
    arb_state_e state_d;
    master_e    last_grant_q;
    master_e    owner_q;
    master_e    winner;
    logic [1:0] req_vec;
    logic [1:0] grant;
    logic       req_hs;

    always_comb begin
        req_vec          = '0;
        req_vec[IFU_IDX] = ifu_req_valid;
        req_vec[LSU_IDX] = lsu_req_valid;
    end

    rr_arb2 u_rr_arb2 (
        .req        (req_vec),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign winner = grant_owner(grant);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and master-side ready. Ready depends only on the
    // request valids and the state, never on the memory-side inputs.
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        req_hs        = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                ifu_req_ready = grant[IFU_IDX];
                lsu_req_ready = grant[LSU_IDX];
                req_hs        = |grant;
                if (req_hs) begin
                    state_d = ARB_REQ;
                end
            end
            ARB_REQ: begin
                // mem_req_valid is always high in this state.
                if (mem_req_ready) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (mem_resp_valid) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, ownership, response latch and registered outputs.
    // mem_req_valid tracks ARB_REQ exactly but is kept as its own flop
    // so the memory side sees a registered signal.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q   <= MST_LSU;
            owner_q        <= MST_IFU;
            mem_req_valid  <= 1'b0;
            mem_addr       <= '0;
            mem_wen        <= 1'b0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            rdata          <= '0;
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (req_hs) begin
                        owner_q       <= winner;
                        last_grant_q  <= winner;
                        mem_req_valid <= 1'b1;
                        if (winner == MST_LSU) begin
                            mem_addr  <= lsu_addr;
                            mem_wen   <= lsu_wen;
                            mem_wdata <= lsu_wdata;
                            mem_wmask <= lsu_wmask;
                        end else begin
                            // IFU is read-only: store fields are forced clear.
                            mem_addr  <= ifu_addr;
                            mem_wen   <= 1'b0;
                            mem_wdata <= '0;
                            mem_wmask <= '0;
                        end
                    end
                end
                ARB_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                    end
                end
                ARB_WAIT: begin
                    // Responses seen in any other state are dropped.
                    if (mem_resp_valid) begin
                        rdata          <= mem_rdata;
                        ifu_resp_valid <= (owner_q == MST_IFU);
                        lsu_resp_valid <= (owner_q == MST_LSU);
                    end
                end
                ARB_RESP: begin
                    ifu_resp_valid <= 1'b0;
                    lsu_resp_valid <= 1'b0;
                end
                default: begin
                    mem_req_valid  <= 1'b0;
                    ifu_resp_valid <= 1'b0;
                    lsu_resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
